vram_console: RTL and testbench
===============================

Name: vram_console

Overview:
- Text-terminal controller that owns the write/read port of the 80x25 character video RAM (#B8000 window, 4 KB).
- Accepts a byte stream (ASCII plus a small set of control codes) over a valid/ready handshake.
- Writes character/attribute byte pairs into video RAM, and handles line wrap, scroll-up and clear-screen.
- Drives the 11-bit cursor cell index consumed by the VGA text adapter; the VGA adapter keeps its own independent read port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen; COLS*ROWS*2 must be <= 4096.
- FILL_CHAR, 8'h20, character written by clear and scroll fill.
- CLEAR_ON_RESET, 1, if 1 the full screen is cleared after reset release.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  character or control code.
- in_attr  in  8  attribute byte; sampled together with in_data.
- in_valid  in  1  in_data/in_attr valid.
- in_ready  out  1  controller accepts a byte this cycle.
- vram_addr  out  12  byte address; shared for read and write.
- vram_wdata  out  8  write data.
- vram_we  out  1  write strobe, one byte per cycle.
- vram_rdata  in  8  read data, valid 1 cycle after vram_addr is presented.
- cursor  out  11  cursor cell index = row*COLS+col.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Memory layout: cell n occupies byte 2n (character) and byte 2n+1 (attribute).
- Reset values: cursor=0, vram_we=0, vram_addr=0, vram_wdata=0, in_ready=0, busy=1 if CLEAR_ON_RESET else 0, last attribute=8'h07.
- After reset: state FILL over all cells if CLEAR_ON_RESET, else IDLE.
- States: IDLE, PUT_CH, PUT_AT, SCR_RD, SCR_WR, FILL.
- in_ready=1 only in IDLE. A transfer occurs when in_valid && in_ready; in_data and in_attr are latched on that cycle.
- Printable byte (>=8'h20, including >=8'h80):
  - PUT_CH: we=1, addr=2*cursor, wdata=char.
  - PUT_AT: we=1, addr=2*cursor+1, wdata=attr.
  - Then the cursor advances and the state returns to IDLE, so the next accept can occur 3 cycles after the previous one.
- Cursor advance:
  - col+1.
  - col==COLS wraps to col 0, row+1.
  - row==ROWS triggers a scroll; cursor=(ROWS-1)*COLS at scroll entry.
- 8'h0D CR: col=0; consumed in one cycle, no memory access.
- 8'h0A LF: row+1 with col unchanged; on the last row, scroll and keep col.
- 8'h08 BS:
  - col>0: col-1, then PUT_CH/PUT_AT writing FILL_CHAR and the latched attribute.
  - col==0: no operation, no wrap to the previous row.
- 8'h0C FF: FILL over all cells, then cursor=0.
- Other codes <8'h20: consumed, ignored.
- Scroll:
  - Copy bytes [2*COLS .. 2*COLS*ROWS-1] down by 2*COLS, ascending address order.
  - SCR_RD presents the source address with we=0; SCR_WR writes vram_rdata to source-2*COLS with we=1.
  - Cost is 2 cycles per byte: 7680 cycles for 80x25.
  - Then FILL the last row: COLS cells, alternating FILL_CHAR/attribute writes, 160 cycles.
- FILL writes one byte per cycle at ascending addresses: even address = FILL_CHAR, odd address = the latched attribute (8'h07 after reset).
  - Full screen = 4000 cycles at 80x25.
- cursor updates only at operation end (or scroll entry) and never exceeds COLS*ROWS-1.
- vram_we deasserts in the cycle the state returns to IDLE.
- in_valid is ignored while busy; no byte is dropped because in_ready=0.
- Reset asserted mid-operation aborts immediately to reset values. Partially copied or filled memory is left as is; a new clear runs if CLEAR_ON_RESET.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 -> exactly 4000 writes: even addresses 8'h20, odd addresses 8'h07; busy low and in_ready high afterwards; cursor=0.
- Send 8'h41 with attr 8'h1E at cursor 0 -> write 8'h41@0, then 8'h1E@1, on consecutive cycles; cursor=1; next accept 3 cycles after the first.
- Cursor=79, send 8'h42 -> writes @158/159; cursor=80. Then CR+BS at col 0 -> cursor stays 80, no writes.
- Cursor=1999, send 8'h43 -> writes @3998/3999, then scroll:
  - byte 160 copied to 0, byte 3999 copied to 3839;
  - 3840..3999 filled;
  - busy for 7680+160 cycles;
  - cursor=1920.
- LF at row 24 col 5 -> scroll; cursor=1925. BS at col 5 -> writes 8'h20@3848, attr@3849; cursor=1924.
- Assert reset mid-scroll (e.g. 1000 cycles in) -> vram_we=0 asynchronously; cursor=0; clear sequence restarts after release.

Source files
------------

// File: rtl/vram_console_if.sv
// Byte-stream and video-RAM port bundle for the text console.
// master = stream producer and RAM side; slave = the console.
interface vram_console_if;
  logic [7:0]  in_data;
  logic [7:0]  in_attr;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;

  modport master (
    output in_data,
    output in_attr,
    output in_valid,
    output vram_rdata,
    input  in_ready,
    input  vram_addr,
    input  vram_wdata,
    input  vram_we
  );

  modport slave (
    input  in_data,
    input  in_attr,
    input  in_valid,
    input  vram_rdata,
    output in_ready,
    output vram_addr,
    output vram_wdata,
    output vram_we
  );
endinterface

// File: rtl/vram_console.sv
// Text-terminal controller: writes char/attr pairs into video RAM,
// handles wrap, scroll-up, backspace and clear-screen.
module vram_console #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 25,
  parameter logic [7:0] FILL_CHAR      = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  vram_console_if.slave bus,
  output logic [10:0]   cursor,
  output logic          busy
);
  localparam int CELLS = COLS * ROWS;
  localparam int CW    = $clog2(COLS + 1);
  localparam int RW    = $clog2(ROWS + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [12:0]   END_ALL  = 13'(2 * CELLS);
  localparam logic [12:0]   LINE_B   = 13'(2 * COLS);
  localparam logic [12:0]   LAST_SRC = 13'(2 * CELLS - 1);
  localparam logic [12:0]   TAIL_B   = 13'(2 * CELLS - 2 * COLS);

  typedef enum logic [2:0] {
    IDLE, PUT_CH, PUT_AT, SCR_RD, SCR_WR, FILL
  } state_t;

  state_t        state, nxt_state;
  logic [RW-1:0] row, nxt_row;
  logic [CW-1:0] col, nxt_col;
  logic [10:0]   put_cell, nxt_cell;
  logic          put_bs, nxt_bs;
  logic [7:0]    attr_q, nxt_attr;
  logic [12:0]   ptr, nxt_ptr;
  logic [12:0]   fend, nxt_end;
  logic          home, nxt_home;
  logic          we_q, nxt_we;
  logic [11:0]   addr_q, nxt_addr;
  logic [7:0]    wd_q, nxt_wd;
  logic          rdy_q;
  logic          scroll;

  logic [10:0] cur_cell;
  logic        take;
  logic        is_print, is_cr, is_lf, is_bs, is_ff;

  assign cur_cell = 11'(row) * 11'(COLS) + 11'(col);
  assign take     = bus.in_valid && rdy_q;
  assign is_print = bus.in_data >= 8'h20;
  assign is_cr    = bus.in_data == 8'h0D;
  assign is_lf    = bus.in_data == 8'h0A;
  assign is_bs    = bus.in_data == 8'h08;
  assign is_ff    = bus.in_data == 8'h0C;

  // Bus registers hold the access of the current state; ptr is the
  // next byte (fill) or the current source byte (scroll).
  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    nxt_cell  = put_cell;
    nxt_bs    = put_bs;
    nxt_attr  = attr_q;
    nxt_ptr   = ptr;
    nxt_end   = fend;
    nxt_home  = home;
    nxt_we    = 1'b0;
    nxt_addr  = addr_q;
    nxt_wd    = wd_q;
    scroll    = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          nxt_attr = bus.in_attr;
          unique case (1'b1)
            is_print: begin
              nxt_state = PUT_CH;
              nxt_cell  = cur_cell;
              nxt_bs    = 1'b0;
              nxt_we    = 1'b1;
              nxt_addr  = {cur_cell, 1'b0};
              nxt_wd    = bus.in_data;
            end
            is_cr: nxt_col = '0;
            is_lf: begin
              if (row == LAST_ROW) scroll = 1'b1;
              else nxt_row = row + RW'(1);
            end
            is_bs: begin
              if (col != '0) begin
                nxt_state = PUT_CH;
                nxt_cell  = cur_cell - 11'd1;
                nxt_bs    = 1'b1;
                nxt_we    = 1'b1;
                nxt_addr  = {cur_cell - 11'd1, 1'b0};
                nxt_wd    = FILL_CHAR;
              end
            end
            is_ff: begin
              nxt_state = FILL;
              nxt_home  = 1'b1;
              nxt_we    = 1'b1;
              nxt_addr  = '0;
              nxt_wd    = FILL_CHAR;
              nxt_ptr   = 13'd1;
              nxt_end   = END_ALL;
            end
            default: ;
          endcase
        end
      end
      PUT_CH: begin
        nxt_state = PUT_AT;
        nxt_we    = 1'b1;
        nxt_addr  = {put_cell, 1'b1};
        nxt_wd    = attr_q;
      end
      PUT_AT: begin
        nxt_state = IDLE;
        if (put_bs) begin
          nxt_col = col - CW'(1);
        end else if (col != LAST_COL) begin
          nxt_col = col + CW'(1);
        end else begin
          nxt_col = '0;
          if (row == LAST_ROW) scroll = 1'b1;
          else nxt_row = row + RW'(1);
        end
      end
      SCR_RD: begin
        nxt_state = SCR_WR;
        nxt_we    = 1'b1;
        nxt_addr  = 12'(ptr - LINE_B);
      end
      SCR_WR: begin
        if (ptr == LAST_SRC) begin
          nxt_state = FILL;
          nxt_home  = 1'b0;
          nxt_we    = 1'b1;
          nxt_addr  = 12'(TAIL_B);
          nxt_wd    = FILL_CHAR;
          nxt_ptr   = TAIL_B + 13'd1;
          nxt_end   = END_ALL;
        end else begin
          nxt_state = SCR_RD;
          nxt_ptr   = ptr + 13'd1;
          nxt_addr  = 12'(ptr + 13'd1);
        end
      end
      FILL: begin
        if (ptr == fend) begin
          nxt_state = IDLE;
          if (home) begin
            nxt_row  = '0;
            nxt_col  = '0;
            nxt_home = 1'b0;
          end
        end else begin
          nxt_we   = 1'b1;
          nxt_addr = 12'(ptr);
          nxt_wd   = ptr[0] ? attr_q : FILL_CHAR;
          nxt_ptr  = ptr + 13'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (scroll) begin
      nxt_state = SCR_RD;
      nxt_we    = 1'b0;
      nxt_ptr   = LINE_B;
      nxt_addr  = 12'(LINE_B);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= CLEAR_ON_RESET ? FILL : IDLE;
      row      <= '0;
      col      <= '0;
      put_cell <= '0;
      put_bs   <= 1'b0;
      attr_q   <= 8'h07;
      ptr      <= '0;
      fend     <= END_ALL;
      home     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state    <= nxt_state;
      row      <= nxt_row;
      col      <= nxt_col;
      put_cell <= nxt_cell;
      put_bs   <= nxt_bs;
      attr_q   <= nxt_attr;
      ptr      <= nxt_ptr;
      fend     <= nxt_end;
      home     <= nxt_home;
      we_q     <= nxt_we;
      addr_q   <= nxt_addr;
      wd_q     <= nxt_wd;
      rdy_q    <= nxt_state == IDLE;
    end
  end

  // Scroll copy forwards the RAM read data straight to the write port.
  assign bus.vram_wdata = (state == SCR_WR) ? bus.vram_rdata : wd_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_addr  = addr_q;
  assign bus.in_ready   = rdy_q;
  assign cursor         = cur_cell;
  assign busy           = state != IDLE;
endmodule

// File: tb/tb_vram_console.sv
// Bench for vram_console: RAM model, screen-level reference model,
// vector table, corner-case sequences and random byte stream.
module tb_vram_console;
  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;
  localparam int SCROLL_CYC = 4 * (CELLS - COLS) + 2 * COLS;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] cursor;
  logic        busy;

  vram_console_if bus ();

  vram_console dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .cursor(cursor),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] mem [4096];
  wr_t wlog[$];
  int  acc[$];
  int  cyc_no = 0;

  always @(posedge clock) begin
    cyc_no <= cyc_no + 1;
    if (bus.vram_we) begin
      mem[bus.vram_addr] <= bus.vram_wdata;
      wlog.push_back(wr_t'{cyc_no, bus.vram_addr, bus.vram_wdata});
    end
    if (bus.in_valid && bus.in_ready) acc.push_back(cyc_no);
    bus.vram_rdata <= mem[bus.vram_addr];
  end

  logic [7:0] mch [CELLS];
  logic [7:0] mat [CELLS];
  int         mcur;
  logic [7:0] mattr;
  int vecs = 0;
  int bad  = 0;

  function automatic void check(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  function automatic void m_clear(logic [7:0] a);
    for (int i = 0; i < CELLS; i++) begin
      mch[i] = 8'h20;
      mat[i] = a;
    end
  endfunction

  function automatic void m_scroll();
    for (int i = 0; i < CELLS - COLS; i++) begin
      mch[i] = mch[i + COLS];
      mat[i] = mat[i + COLS];
    end
    for (int i = CELLS - COLS; i < CELLS; i++) begin
      mch[i] = 8'h20;
      mat[i] = mattr;
    end
  endfunction

  // Applies one byte to the screen model; returns expected busy cycles.
  function automatic int m_byte(logic [7:0] d, logic [7:0] a);
    int c = 0;
    mattr = a;
    if (d >= 8'h20) begin
      mch[mcur] = d;
      mat[mcur] = a;
      mcur++;
      c = 2;
      if (mcur == CELLS) begin
        m_scroll();
        mcur = CELLS - COLS;
        c += SCROLL_CYC;
      end
    end else if (d == 8'h0D) begin
      mcur -= mcur % COLS;
    end else if (d == 8'h0A) begin
      if (mcur / COLS == ROWS - 1) begin
        m_scroll();
        c = SCROLL_CYC;
      end else begin
        mcur += COLS;
      end
    end else if (d == 8'h08) begin
      if (mcur % COLS != 0) begin
        mcur--;
        mch[mcur] = 8'h20;
        mat[mcur] = a;
        c = 2;
      end
    end else if (d == 8'h0C) begin
      m_clear(a);
      mcur = 0;
      c = 2 * CELLS;
    end
    return c;
  endfunction

  function automatic int screen_diffs();
    int n = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (mem[2*i] !== mch[i]) n++;
      if (mem[2*i+1] !== mat[i]) n++;
    end
    return n;
  endfunction

  function automatic void check_wr(string name, int idx, int addr, int data);
    if (idx >= wlog.size()) begin
      check({name, "_present"}, wlog.size(), idx + 1);
    end else begin
      check({name, "_addr"}, int'(wlog[idx].addr), addr);
      check({name, "_data"}, int'(wlog[idx].data), data);
    end
  endfunction

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a,
                      input bit wait_done, output int cyc);
    int t = 0;
    cyc = 0;
    @(negedge clock);
    while (!bus.in_ready && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20000) check("ready_timeout", t, 0);
    bus.in_data  = d;
    bus.in_attr  = a;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    if (wait_done) wait_idle(cyc);
  endtask

  task automatic do_byte(input logic [7:0] d, input logic [7:0] a,
                         input string tag);
    int cyc, exp;
    exp = m_byte(d, a);
    send(d, a, 1'b1, cyc);
    check({tag, "_cycles"}, cyc, exp);
    check({tag, "_cursor"}, int'(cursor), mcur);
  endtask

  task automatic do_print(input string tag);
    do_byte(8'($urandom_range(32, 255)), 8'($urandom_range(0, 255)), tag);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
    int         cur;
    int         cyc;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    int cyc, n0, base, t, e0;
    logic [7:0] d;

    tbl = '{
      '{8'h0D, 8'h07,   0, 0},
      '{8'h08, 8'h07,   0, 0},
      '{8'h0A, 8'h07,  80, 0},
      '{8'h43, 8'h4A,  81, 2},
      '{8'h44, 8'h4A,  82, 2},
      '{8'h08, 8'h5B,  81, 2},
      '{8'h01, 8'h07,  81, 0},
      '{8'h1B, 8'h07,  81, 0},
      '{8'h7F, 8'h33,  82, 2},
      '{8'hC3, 8'h71,  83, 2},
      '{8'h0A, 8'h07, 163, 0},
      '{8'h0D, 8'h07, 160, 0},
      '{8'h20, 8'h07, 161, 2},
      '{8'h0D, 8'h07, 160, 0}
    };

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_attr  = '0;

    #12;
    check("rst_we", int'(bus.vram_we), 0);
    check("rst_addr", int'(bus.vram_addr), 0);
    check("rst_wdata", int'(bus.vram_wdata), 0);
    check("rst_ready", int'(bus.in_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cursor", int'(cursor), 0);

    @(negedge clock);
    reset = 1'b0;
    n0 = wlog.size();
    wait_idle(cyc);
    check("clear_writes", wlog.size() - n0, 4000);
    m_clear(8'h07);
    mcur  = 0;
    mattr = 8'h07;
    check("clear_screen", screen_diffs(), 0);
    check("clear_cursor", int'(cursor), 0);
    check("clear_ready", int'(bus.in_ready), 1);

    // Back-to-back bytes with in_valid held high.
    base = acc.size();
    n0   = wlog.size();
    @(negedge clock);
    bus.in_data  = 8'h41;
    bus.in_attr  = 8'h1E;
    bus.in_valid = 1'b1;
    t = 0;
    while (acc.size() < base + 1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    bus.in_data = 8'h42;
    while (acc.size() < base + 2 && t < 100) begin
      @(negedge clock);
      t++;
    end
    bus.in_valid = 1'b0;
    check("A_cursor", int'(cursor), 1);
    check("accept_gap", acc[base+1] - acc[base], 3);
    check_wr("A_ch", n0, 0, 8'h41);
    check_wr("A_at", n0 + 1, 1, 8'h1E);
    if (n0 + 1 < wlog.size()) begin
      check("A_ch_cycle", wlog[n0].cyc - acc[base], 1);
      check("A_at_cycle", wlog[n0+1].cyc - acc[base], 2);
    end
    wait_idle(cyc);
    e0 = m_byte(8'h41, 8'h1E);
    e0 = m_byte(8'h42, 8'h1E);
    check("AB_cursor", int'(cursor), mcur);

    for (int i = 0; i < 14; i++) begin
      e0 = m_byte(tbl[i].d, tbl[i].a);
      send(tbl[i].d, tbl[i].a, 1'b1, cyc);
      check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("tbl%0d_cursor", i), int'(cursor), tbl[i].cur);
    end
    check("tbl_screen", screen_diffs(), 0);

    // Wrap at the end of the first row.
    do_byte(8'h0C, 8'h07, "ff");
    for (int i = 0; i < 79; i++) do_print("row0");
    n0 = wlog.size();
    do_byte(8'h42, 8'h2C, "col79");
    check("col79_cursor_abs", int'(cursor), 80);
    check_wr("col79_ch", n0, 158, 8'h42);
    check_wr("col79_at", n0 + 1, 159, 8'h2C);
    n0 = wlog.size();
    do_byte(8'h0D, 8'h07, "cr0");
    do_byte(8'h08, 8'h07, "bs0");
    check("crbs_writes", wlog.size() - n0, 0);
    check("crbs_cursor", int'(cursor), 80);

    // Printable in the last cell triggers the scroll.
    for (int i = 0; i < 23; i++) do_byte(8'h0A, 8'h07, "lf");
    for (int i = 0; i < 79; i++) do_print("row24");
    check("pre_scroll_cursor", int'(cursor), 1999);
    e0 = int'(mch[COLS]);
    n0 = wlog.size();
    do_byte(8'h43, 8'h5D, "wrap_scroll");
    check("scroll_cursor", int'(cursor), 1920);
    check_wr("last_ch", n0, 3998, 8'h43);
    check_wr("last_at", n0 + 1, 3999, 8'h5D);
    check("scroll_writes", wlog.size() - n0, 2 + 3840 + 160);
    check("scroll_byte0", int'(mem[0]), e0);
    check("scroll_byte3839", int'(mem[3839]), 8'h5D);
    check("scroll_screen", screen_diffs(), 0);

    // LF on the last row keeps the column; BS then blanks a cell.
    for (int i = 0; i < 5; i++) do_print("row24b");
    do_byte(8'h0A, 8'h3C, "lf_scroll");
    check("lf_scroll_cursor", int'(cursor), 1925);
    n0 = wlog.size();
    do_byte(8'h08, 8'h6E, "bs5");
    check("bs5_cursor", int'(cursor), 1924);
    check_wr("bs5_ch", n0, 3848, 8'h20);
    check_wr("bs5_at", n0 + 1, 3849, 8'h6E);
    check("lf_bs_screen", screen_diffs(), 0);

    // Reset in the middle of a scroll.
    send(8'h0A, 8'h07, 1'b0, cyc);
    repeat (1000) @(negedge clock);
    check("midscroll_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_we", int'(bus.vram_we), 0);
    check("midrst_cursor", int'(cursor), 0);
    check("midrst_ready", int'(bus.in_ready), 0);
    check("midrst_busy", int'(busy), 1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    n0 = wlog.size();
    wait_idle(cyc);
    check("reclear_writes", wlog.size() - n0, 4000);
    m_clear(8'h07);
    mcur  = 0;
    mattr = 8'h07;
    check("reclear_screen", screen_diffs(), 0);
    check("reclear_cursor", int'(cursor), 0);

    for (int i = 0; i < 200; i++) begin
      t = $urandom_range(0, 99);
      if (t < 70) begin
        d = 8'($urandom_range(32, 255));
      end else if (t < 78) begin
        d = 8'h0D;
      end else if (t < 83) begin
        d = 8'h0A;
      end else if (t < 93) begin
        d = 8'h08;
      end else begin
        d = 8'($urandom_range(0, 31));
        if (d == 8'h08 || d == 8'h0A || d == 8'h0C || d == 8'h0D)
          d = 8'h1F;
      end
      do_byte(d, 8'($urandom_range(0, 255)), "rnd");
    end
    check("rnd_screen", screen_diffs(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
